// File: rtl/cordic_sqrt_pkg.sv
// Shared constants, width helpers and stage layout for the cordic_0
// pipelined integer square-root engine.
package cordic_sqrt_pkg;

  localparam int DATA_W_DEF = 16;

  // One result bit is resolved per stage.
  function automatic int STAGES(input int data_w);
    return data_w / 2;
  endfunction

  // The partial remainder never exceeds 2*root, so two bits above the root
  // width hold it together with the pair of radicand bits shifted in.
  function automatic int rem_w(input int data_w);
    return data_w / 2 + 2;
  endfunction

  // Per-stage state at the default width. The RTL carries the same fields
  // as separate vectors sized by DATA_W so that other widths also build.
  typedef struct packed {
    logic                       vld;
    logic [DATA_W_DEF/2-1:0]    root;
    logic [DATA_W_DEF/2+1:0]    rem;
    logic [DATA_W_DEF-1:0]      rad;
  } stage_t;

endpackage

// File: rtl/cordic_sqrt_stage.sv
// One restoring shift-subtract square-root step followed by its pipeline
// register. Data registers load only when the incoming valid is set; the
// valid bit always shifts.
module cordic_sqrt_stage
  import cordic_sqrt_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  localparam int RT     = STAGES(DATA_W),
  localparam int RW     = rem_w(DATA_W)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          vld_i,
  input  logic [1:0]    bits_i,
  input  logic [RT-1:0] root_i,
  input  logic [RW-1:0] rem_i,
  output logic          vld_o,
  output logic [RT-1:0] root_o,
  output logic [RW-1:0] rem_o
);

  logic [RW+1:0] sh;
  logic [RW-1:0] sub;
  logic [RW-1:0] diff;
  logic          ge;
  logic [RT-1:0] root_d;
  logic [RW-1:0] rem_d;
  logic          vld_q;
  logic [RT-1:0] root_q;
  logic [RW-1:0] rem_q;

  // Trial value: (rem<<2 | next pair) - (root<<2 | 1). The compare uses the
  // full shifted width; the subtraction only needs RW bits because a
  // non-negative trial is always below 2^RW.
  assign sh   = {rem_i, bits_i};
  assign sub  = {root_i, 2'b01};
  assign ge   = (sh >= {2'b00, sub});
  assign diff = sh[RW-1:0] - sub;

  // Next partial root and restoring remainder.
  always_comb begin
    root_d = {root_i[RT-2:0], ge};
    rem_d  = ge ? diff : sh[RW-1:0];
  end

  // Stage register: valid always advances, data only with a valid sample.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q  <= 1'b0;
      root_q <= '0;
      rem_q  <= '0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) begin
        root_q <= root_d;
        rem_q  <= rem_d;
      end
    end
  end

  assign vld_o  = vld_q;
  assign root_o = root_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/cordic_0.sv
// cordic_0: fully pipelined unsigned integer square root, one sample per
// clock, fixed latency, valid-only streaming interfaces.
// Default build: floor(sqrt(X)) with latency DATA_W/2.
// Define CORDIC_SQRT_ROUND_EN for round-to-nearest output; this adds one
// register stage (latency DATA_W/2+1).
module cordic_0
  import cordic_sqrt_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  localparam int ROOT_W = DATA_W / 2 + 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_axis_cartesian_tvalid,
  input  logic [DATA_W-1:0] s_axis_cartesian_tdata,
  output logic              m_axis_dout_tvalid,
  output logic [DATA_W-1:0] m_axis_dout_tdata
);

  localparam int N  = STAGES(DATA_W);
  localparam int RW = rem_w(DATA_W);

  // Index i is the input to stage i; index N is the last stage's output.
  logic [N:0]             vld_pipe;
  logic [N:0][N-1:0]      root_pipe;
  logic [N:0][RW-1:0]     rem_pipe;
  logic [N-1:0][1:0]      bits;

  logic                   out_vld_q;
  logic [ROOT_W-1:0]      out_q;

  assign vld_pipe[0]  = s_axis_cartesian_tvalid;
  assign root_pipe[0] = '0;
  assign rem_pipe[0]  = '0;
  assign bits[0]      = s_axis_cartesian_tdata[DATA_W-1 -: 2];

  // Unconsumed radicand bits travel beside the stages, shrinking by one
  // pair per stage so nothing already consumed is kept.
  for (genvar i = 1; i < N; i++) begin : rad_g
    logic [DATA_W-2*i-1:0] rad_q;
    logic [DATA_W-2*i-1:0] rad_d;

    if (i == 1) begin : g_src
      assign rad_d = s_axis_cartesian_tdata[DATA_W-3:0];
    end else begin : g_src
      assign rad_d = rad_g[i-1].rad_q[DATA_W-2*i-1:0];
    end

    // Loads together with stage i-1, which consumes the pair above these bits.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)          rad_q <= '0;
      else if (vld_pipe[i-1]) rad_q <= rad_d;
    end

    assign bits[i] = rad_q[DATA_W-2*i-1 -: 2];
  end

  for (genvar i = 0; i < N; i++) begin : stg_g
    cordic_sqrt_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .aclk    (aclk),
      .aresetn (aresetn),
      .vld_i   (vld_pipe[i]),
      .bits_i  (bits[i]),
      .root_i  (root_pipe[i]),
      .rem_i   (rem_pipe[i]),
      .vld_o   (vld_pipe[i+1]),
      .root_o  (root_pipe[i+1]),
      .rem_o   (rem_pipe[i+1])
    );
  end

`ifdef CORDIC_SQRT_ROUND_EN
  logic              rnd_vld_q;
  logic [ROOT_W-1:0] rnd_q;
  logic [ROOT_W-1:0] rnd_d;
  logic              rnd_up;

  // remainder > root is the same as X >= root^2+root+1: round up.
  assign rnd_up = (rem_pipe[N] > {2'b00, root_pipe[N]});
  assign rnd_d  = {1'b0, root_pipe[N]} + {{(ROOT_W-1){1'b0}}, rnd_up};

  // Rounding register; the extra bit holds the 2^(DATA_W/2) case.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rnd_vld_q <= 1'b0;
      rnd_q     <= '0;
    end else begin
      rnd_vld_q <= vld_pipe[N];
      if (vld_pipe[N]) rnd_q <= rnd_d;
    end
  end

  // Output register; data holds its last value between valid pulses.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      out_vld_q <= rnd_vld_q;
      if (rnd_vld_q) out_q <= rnd_q;
    end
  end
`else
  // Output register; data holds its last value between valid pulses.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      out_vld_q <= vld_pipe[N];
      if (vld_pipe[N]) out_q <= {1'b0, root_pipe[N]};
    end
  end
`endif

  assign m_axis_dout_tvalid = out_vld_q;
  assign m_axis_dout_tdata  = {{(DATA_W-ROOT_W){1'b0}}, out_q};

endmodule

// File: tb/tb_cordic_0.sv
// Self-checking bench for cordic_0 (DATA_W=16): constant vector table,
// burst/gap streaming, mid-flight asynchronous reset and an exhaustive sweep,
// all checked through an in-order scoreboard with latency tracking.
module tb_cordic_0;

`ifdef CORDIC_SQRT_ROUND_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  logic        aclk;
  logic        aresetn;
  logic        s_tvalid;
  logic [15:0] s_tdata;
  logic        m_tvalid;
  logic [15:0] m_tdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] exp;
    int          acc;
  } sb_t;
  sb_t sb[$];
  sb_t mon_e;

  typedef struct {
    logic [15:0] x;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[8];

  cordic_0 dut (
    .aclk                    (aclk),
    .aresetn                 (aresetn),
    .s_axis_cartesian_tvalid (s_tvalid),
    .s_axis_cartesian_tdata  (s_tdata),
    .m_axis_dout_tvalid      (m_tvalid),
    .m_axis_dout_tdata       (m_tdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc++;

  // Reference root by greedy bit-setting on the square (independent of the
  // restoring remainder recurrence).
  function automatic logic [15:0] ref_root(input int x);
    int r;
    r = 0;
    for (int b = 128; b >= 1; b = b / 2)
      if ((r + b) * (r + b) <= x) r += b;
`ifdef CORDIC_SQRT_ROUND_EN
    if (x >= r * r + r + 1) r++;
`endif
    return r[15:0];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One input cycle; a valid sample queues its expected root and the edge
  // on which it is accepted.
  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] e);
    sb_t s;
    @(posedge aclk);
    #1;
    s_tvalid = v;
    s_tdata  = v ? x : 16'($urandom);
    if (v) begin
      s.exp = e;
      s.acc = cyc + 1;
      sb.push_back(s);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 16'h0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      drive(1'b0, 16'h0, 16'h0);
      n++;
    end
    check({name, "_drain_left"}, sb.size(), 0);
    idle(LAT + 3);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge aclk) begin
    if (m_tvalid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_valid got data=%0d expected no valid", m_tdata);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (m_tdata !== mon_e.exp) begin
          failures++;
          $display("FAIL data got=%0d expected=%0d", m_tdata, mon_e.exp);
        end
        checks++;
        if (cyc != mon_e.acc + LAT) begin
          failures++;
          $display("FAIL latency got=%0d expected=%0d", cyc - mon_e.acc, LAT);
        end
      end
    end
  end

  initial begin
    vecs[0] = '{16'd1024,  16'd32};
    vecs[1] = '{16'd0,     16'd0};
    vecs[2] = '{16'd1,     16'd1};
    vecs[3] = '{16'd2,     16'd1};
    vecs[4] = '{16'd65025, 16'd255};
    vecs[5] = '{16'd144,   16'd12};
`ifdef CORDIC_SQRT_ROUND_EN
    vecs[6] = '{16'd3,     16'd2};
    vecs[7] = '{16'd65535, 16'd256};
`else
    vecs[6] = '{16'd3,     16'd1};
    vecs[7] = '{16'd65535, 16'd255};
`endif

    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 16'h0;
    repeat (3) @(posedge aclk);
    #1;
    check("reset_tvalid", int'(m_tvalid), 0);
    check("reset_tdata", int'(m_tdata), 0);
    aresetn = 1'b1;
    idle(2);

    // Isolated pulses from the constant table.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].x, vecs[i].exp);
      idle(LAT + 3);
    end
    check("table_drained", sb.size(), 0);

    // Data holds between pulses: last table entry is still on the output.
    #2;
    check("hold_tdata", int'(m_tdata), int'(vecs[7].exp));

    // Burst of 16, a 3-cycle gap, then 4 more.
    for (int i = 0; i < 16; i++) begin
      logic [15:0] x;
      x = 16'($urandom_range(0, 65535));
      drive(1'b1, x, ref_root(int'(x)));
    end
    idle(3);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] x;
      x = 16'($urandom_range(0, 65535));
      drive(1'b1, x, ref_root(int'(x)));
    end
    drain("burst");

    // Asynchronous reset with samples in flight and a valid on the output.
    for (int i = 0; i < 12; i++) drive(1'b1, 16'd40000, 16'd200);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    #2;
    check("pre_reset_tvalid", int'(m_tvalid), 1);
    check("pre_reset_tdata", int'(m_tdata), 200);
    aresetn = 1'b0;
    #1;
    check("async_reset_tvalid", int'(m_tvalid), 0);
    check("async_reset_tdata", int'(m_tdata), 0);
    sb.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    idle(LAT + 6);
    drive(1'b1, 16'd144, 16'd12);
    drain("post_reset");

    // Exhaustive sweep, back to back.
    for (int x = 0; x < 65536; x++) drive(1'b1, 16'(x), ref_root(x));
    drain("sweep");

    check("final_queue_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_0.md
Name: cordic_0

Overview:
- Pipelined unsigned integer square-root engine, drop-in for the vendor CORDIC square-root core.
- Used by the fusion datapath wherever a magnitude or root of a 16-bit unsigned value is needed.
- AXI-Stream-style input and output with valid only: no backpressure, one result per clock at full throughput, fixed latency.

Parameters:
- DATA_W, 16, input width in bits; must be even and at least 4.
- ROOT_W, DATA_W/2+1, derived constant (not overridable); significant result bits before zero-extension.

Ports:
- aclk  in  1  clock; all state updates on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_cartesian_tvalid  in  1  input sample valid; no tready, every valid sample is accepted.
- s_axis_cartesian_tdata  in  DATA_W  unsigned radicand X.
- m_axis_dout_tvalid  out  1  result valid, high for exactly one cycle per accepted input.
- m_axis_dout_tdata  out  DATA_W  root, zero-extended from ROOT_W bits.

Behaviour:
- Reset: while aresetn is 0, all pipeline valid bits and data registers clear to 0 immediately, independent of aclk.
  - m_axis_dout_tvalid=0 and m_axis_dout_tdata=0 during reset.
  - Samples in flight are discarded; no output is produced for them after reset deasserts.
- Function, default build: result = floor(sqrt(X)), computed exactly with no approximation error.
  - Range 0..255 for DATA_W=16; bit 8 and above are 0.
- Algorithm: restoring digit-by-digit (shift-subtract) square root, one result bit per stage, MSB first.
  - Number of stages is N = DATA_W/2.
  - Stage i carries the partial root, the partial remainder (DATA_W/2+2 bits, unsigned) and the unconsumed radicand bits.
  - Trial value is (rem<<2 | next 2 radicand bits) - (root<<2 | 1).
  - If the trial value is >= 0: rem takes the trial value and the root bit is 1.
  - Otherwise: rem takes the shifted value and the root bit is 0.
- Latency: a sample accepted on rising edge k (tvalid=1) appears with m_axis_dout_tvalid=1 after rising edge k+N (8 cycles for DATA_W=16).
  - Latency is fixed and data-independent.
- Throughput: one sample per cycle. Back-to-back valid inputs produce back-to-back outputs in the same order.
- Bubbles: an idle input cycle (tvalid=0) produces an idle output cycle N cycles later.
  - m_axis_dout_tdata holds its last valid value while m_axis_dout_tvalid=0.
- Data register updates: registers in a stage load only when that stage's valid bit is 1.
  - Valid bits always shift.
- Boundaries:
  - X=0 gives 0.
  - X=all-ones gives 2^(DATA_W/2)-1.
  - Perfect squares give the exact root with remainder 0.
- s_axis_cartesian_tdata is don't-care when tvalid=0.

Optional Feature:
- Macro: CORDIC_SQRT_ROUND_EN.
- Defined: round-to-nearest is added to the output.
  - After the final stage, if remainder > root, the result is root+1.
  - This is equivalent to X >= root^2+root+1; the result is still an exact integer.
  - One extra register stage is added, so latency becomes N+1.
  - Maximum output is 2^(DATA_W/2) (256 for 16 bits), which needs ROOT_W bits.
- Undefined: truncated floor result with latency N.

Decomposition:
- Package cordic_sqrt_pkg holds:
  - constants DATA_W_DEF=16 and STAGES(DATA_W)=DATA_W/2;
  - the remainder width function;
  - typedef stage_t (valid, root, rem, radicand).
- One natural sub-module, cordic_sqrt_stage: a single combinational shift-subtract step plus its pipeline register.
  - It is instantiated N times in a generate loop by cordic_0.

Test Plan:
- X=1024 single pulse after reset -> m_axis_dout_tvalid pulses once, 8 cycles later, m_axis_dout_tdata=32; rounding build gives 32 after 9 cycles.
- X=0, 1, 2, 3 -> 0, 1, 1, 1; rounding build gives 0, 1, 1, 2.
- X=65535 -> 255; rounding build gives 256. X=65025 -> 255 in both builds.
- Burst of 16 back-to-back random values, then a 3-cycle gap, then 4 more -> outputs match floor(sqrt) in order, with the same gap pattern and no extra or missing valid pulses.
- Assert aresetn=0 asynchronously while 5 samples are in flight, between clock edges -> outputs clear immediately; after release, no stale valid pulses appear and a new X=144 yields 12.
- Exhaustive sweep of all 65536 inputs streamed back-to-back -> every output equals the reference floor (or rounded) root.
